// File: rtl/pdm_pcm_packer.sv
// pdm_pcm_packer
// Takes the round-robin 16-bit PCM stream from the CIC decimator and tracks
// the channel of each sample. It formats samples into 32-bit words, either one
// sign-extended sample or two packed samples per word. The words are buffered
// in a small FIFO towards the uDMA RX channel. The upstream stream cannot be
// stalled, so a word that finds the FIFO full is dropped and counted.
//
// Optional feature: define PDM_PACKER_CH_TAG_EN to place the sample's channel
// index in bits [31:30] of every word.

module pdm_pcm_packer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int OVF_CNT_WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cfg_en_i,
    input  logic [1:0]                     cfg_ch_num_i,
    input  logic                           cfg_pack_i,
    input  logic                           ovf_clr_i,
    input  logic [15:0]                    pcm_data_i,
    input  logic                           pcm_data_valid_i,
    output logic [31:0]                    data_o,
    output logic                           data_valid_o,
    input  logic                           data_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o,
    output logic                           ovf_o,
    output logic [OVF_CNT_WIDTH-1:0]       ovf_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        EMPTY_HALF = 1'b0,
        HAVE_LOW   = 1'b1
    } pack_state_t;

    // Packing state and the registered commit stage
    pack_state_t state_q;
    logic [1:0]  ch_idx_q;
    logic [15:0] low_q;
    logic        commit_valid_q;
    logic [31:0] commit_word_q;

    // FIFO state
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] count_q;

    logic        ovf_q;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q;

    logic [31:0] unpacked_word;
    logic [31:0] packed_word;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;

    // Candidate words for the current sample; the tag, when built in, is the
    // channel of the sample arriving now (the high half in packed mode)
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        unpacked_word = {{16{pcm_data_i[15]}}, pcm_data_i};
        packed_word   = {pcm_data_i, low_q};
`ifdef PDM_PACKER_CH_TAG_EN
        unpacked_word[31:30] = ch_idx_q;
        packed_word[31:30]   = ch_idx_q;
`else
`endif
    end

    // Channel tracking, packing FSM and commit register
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_i) begin
            state_q        <= EMPTY_HALF;
            ch_idx_q       <= 2'd0;
            low_q          <= 16'd0;
            commit_valid_q <= 1'b0;
            commit_word_q  <= 32'd0;
        end else begin
            commit_valid_q <= 1'b0;
            if (!cfg_en_i) begin
                // Disabling restarts channel alignment and forgets any half word
                state_q  <= EMPTY_HALF;
                ch_idx_q <= 2'd0;
            end else if (pcm_data_valid_i) begin
                ch_idx_q <= (ch_idx_q >= cfg_ch_num_i) ? 2'd0 : ch_idx_q + 2'd1;
                if (!cfg_pack_i) begin
                    commit_valid_q <= 1'b1;
                    commit_word_q  <= unpacked_word;
                end else begin
                    case (state_q)
                        EMPTY_HALF: begin
                            low_q   <= pcm_data_i;
                            state_q <= HAVE_LOW;
                        end
                        HAVE_LOW: begin
                            commit_valid_q <= 1'b1;
                            commit_word_q  <= packed_word;
                            state_q        <= EMPTY_HALF;
                        end
                        default: state_q <= EMPTY_HALF;
                    endcase
                end
            end
        end
    end

    assign full         = (count_q == LW'(FIFO_DEPTH));
    assign data_valid_o = (count_q != '0);
    assign pop          = data_valid_o & data_ready_i;
    // A full FIFO still takes the word when the head leaves in the same cycle
    assign push         = commit_valid_q & (~full | pop);
    assign drop         = commit_valid_q & full & ~pop;

    // Head word is forced to zero while empty so it reads 0 out of reset
    assign data_o       = data_valid_o ? mem[rd_ptr_q] : 32'd0;
    assign fifo_level_o = count_q;

    // FIFO storage write
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; the pointers and count define validity.
        if (push) begin
            mem[wr_ptr_q] <= commit_word_q;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop beats a clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (drop && ovf_clr_i) begin
            ovf_q     <= 1'b1;
            ovf_cnt_q <= OVF_CNT_WIDTH'(1);
        end else if (ovf_clr_i) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != '1) begin
                ovf_cnt_q <= ovf_cnt_q + OVF_CNT_WIDTH'(1);
            end
        end
    end

    assign ovf_o     = ovf_q;
    assign ovf_cnt_o = ovf_cnt_q;

endmodule

// File: tb/tb_pdm_pcm_packer.sv
// Directed testbench for pdm_pcm_packer (FIFO_DEPTH=4, OVF_CNT_WIDTH=8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point too.

module tb_pdm_pcm_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_en_i;
    logic [1:0]  cfg_ch_num_i;
    logic        cfg_pack_i;
    logic        ovf_clr_i;
    logic [15:0] pcm_data_i;
    logic        pcm_data_valid_i;
    logic [31:0] data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic [2:0]  fifo_level_o;
    logic        ovf_o;
    logic [7:0]  ovf_cnt_o;

    int compared   = 0;
    int mismatched = 0;

    pdm_pcm_packer #(
        .FIFO_DEPTH    (4),
        .OVF_CNT_WIDTH (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_ch_num_i     (cfg_ch_num_i),
        .cfg_pack_i       (cfg_pack_i),
        .ovf_clr_i        (ovf_clr_i),
        .pcm_data_i       (pcm_data_i),
        .pcm_data_valid_i (pcm_data_valid_i),
        .data_o           (data_o),
        .data_valid_o     (data_valid_o),
        .data_ready_i     (data_ready_i),
        .fifo_level_o     (fifo_level_o),
        .ovf_o            (ovf_o),
        .ovf_cnt_o        (ovf_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        pcm_data_i       = d;
        pcm_data_valid_i = 1'b1;
        tick();
        pcm_data_valid_i = 1'b0;
    endtask

    // Reconfigure while disabled, then enable again
    task automatic configure(input logic pack, input logic [1:0] ch_num, input logic ready);
        cfg_en_i     = 1'b0;
        cfg_pack_i   = pack;
        cfg_ch_num_i = ch_num;
        data_ready_i = ready;
        tick();
        cfg_en_i     = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_word;

        rst_i            = 1'b1;
        cfg_en_i         = 1'b0;
        cfg_ch_num_i     = 2'd0;
        cfg_pack_i       = 1'b0;
        ovf_clr_i        = 1'b0;
        pcm_data_i       = 16'd0;
        pcm_data_valid_i = 1'b0;
        data_ready_i     = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        // Reset values
        check("rst_data", data_o, 32'h0);
        check("rst_valid", data_valid_o, 32'h0);
        check("rst_level", fifo_level_o, 32'h0);
        check("rst_ovf", ovf_o, 32'h0);
        check("rst_ovf_cnt", ovf_cnt_o, 32'h0);

        // Unpacked, one channel, two-cycle latency
        configure(1'b0, 2'd0, 1'b1);
        send(16'h1234);
        check("unp_lat_n1", data_valid_o, 32'h0);
        tick();
        check("unp_lat_n2", data_valid_o, 32'h1);
        check("unp_word0", data_o, 32'h0000_1234);
        send(16'h8001);
        check("unp_popped", data_valid_o, 32'h0);
        tick();
        check("unp_word1", data_o, 32'hFFFF_8001);
        tick();
        check("unp_drained", data_valid_o, 32'h0);

        // Packed, two channels
        configure(1'b1, 2'd1, 1'b1);
        send(16'hAAAA);
        send(16'h5555);
        check("pk_pending", data_valid_o, 32'h0);
        tick();
        check("pk_level0", fifo_level_o, 32'h1);
        check("pk_word0", data_o, 32'h5555_AAAA);
        send(16'h0001);
        send(16'h0002);
        tick();
        check("pk_level1", fifo_level_o, 32'h1);
        check("pk_word1", data_o, 32'h0002_0001);
        tick();
        check("pk_drained", fifo_level_o, 32'h0);

        // Overflow: six samples into a depth-4 FIFO that is not draining
        configure(1'b0, 2'd0, 1'b0);
        for (int i = 1; i <= 6; i++) send(16'(i));
        tick();
        check("ovf_level", fifo_level_o, 32'h4);
        check("ovf_flag", ovf_o, 32'h1);
        check("ovf_cnt", ovf_cnt_o, 32'h2);
        data_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_drain%0d", i), data_o, 32'(i));
            tick();
        end
        check("ovf_drained", data_valid_o, 32'h0);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("clr_flag", ovf_o, 32'h0);
        check("clr_cnt", ovf_cnt_o, 32'h0);

        // Full FIFO with push and pop in the same cycle
        data_ready_i = 1'b0;
        for (int i = 'h11; i <= 'h14; i++) send(16'(i));
        tick();
        check("pp_full", fifo_level_o, 32'h4);
        send(16'h0015);
        data_ready_i = 1'b1;
        tick();
        data_ready_i = 1'b0;
        check("pp_level", fifo_level_o, 32'h4);
        check("pp_ovf", ovf_o, 32'h0);
        check("pp_ovf_cnt", ovf_cnt_o, 32'h0);
        data_ready_i = 1'b1;
        for (int i = 'h12; i <= 'h15; i++) begin
            check($sformatf("pp_drain%0h", i), data_o, 32'(i));
            tick();
        end
        check("pp_drained", data_valid_o, 32'h0);

        // Packed: disabling discards a lone low half
        configure(1'b1, 2'd1, 1'b1);
        send(16'h0099);
        cfg_en_i = 1'b0;
        tick();
        tick();
        check("dis_no_word", fifo_level_o, 32'h0);
        cfg_en_i = 1'b1;
        send(16'h0003);
        send(16'h0004);
        tick();
        check("dis_realign", data_o, 32'h0004_0003);
        tick();
        check("dis_drained", fifo_level_o, 32'h0);

        // Clear coinciding with a drop, then counter saturation
        configure(1'b0, 2'd0, 1'b0);
        for (int i = 'h21; i <= 'h24; i++) send(16'(i));
        tick();
        send(16'h0025);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("clrdrop_flag", ovf_o, 32'h1);
        check("clrdrop_cnt", ovf_cnt_o, 32'h1);
        for (int i = 0; i < 300; i++) send(16'h0026);
        tick();
        check("sat_cnt", ovf_cnt_o, 32'hFF);
        check("sat_level", fifo_level_o, 32'h4);
        check("sat_head", data_o, 32'h0000_0021);

        // Reset mid-operation empties the FIFO and clears overflow state
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mrst_level", fifo_level_o, 32'h0);
        check("mrst_valid", data_valid_o, 32'h0);
        check("mrst_data", data_o, 32'h0);
        check("mrst_ovf", ovf_o, 32'h0);
        check("mrst_cnt", ovf_cnt_o, 32'h0);
        data_ready_i = 1'b1;
        send(16'h0031);
        tick();
        check("mrst_word", data_o, 32'h0000_0031);
        tick();

`ifdef PDM_PACKER_CH_TAG_EN
        // Channel tags, four channels unpacked
        configure(1'b0, 2'd3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send(16'h0010);
            tick();
            exp_word = {i[1:0], 30'h10};
            check($sformatf("tag%0d", i), data_o, exp_word);
        end
        send(16'h0010);
        send(16'h0010);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("tag_rst_level", fifo_level_o, 32'h0);
        send(16'h0010);
        tick();
        exp_word = {2'd0, 30'h10};
        check("tag_restart", data_o, exp_word);
        tick();
`else
        exp_word = 32'h0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pdm_pcm_packer.md
Name: pdm_pcm_packer

Overview:
- Downstream stage of the PDM front-end (pdm_top).
- Accepts the 16-bit PCM sample stream that the CIC decimator emits round-robin across 1..4 channels.
- Tracks the channel index of each sample and formats samples into 32-bit words, either one sign-extended sample or two packed samples per word.
- Buffers words in a small FIFO towards the uDMA RX channel. The upstream stream cannot be stalled, so overflow drops words and is counted.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit FIFO entries; power of two, >= 2.
- OVF_CNT_WIDTH, 8, width of the saturating dropped-word counter.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- cfg_en_i  input  1  block enable
- cfg_ch_num_i  input  2  number of channels minus 1 (0..3)
- cfg_pack_i  input  1  0: one sample per word; 1: two samples per word
- ovf_clr_i  input  1  clears overflow flag and counter
- pcm_data_i  input  16  signed PCM sample
- pcm_data_valid_i  input  1  sample strobe, single cycle, no backpressure
- data_o  output  32  FIFO head word to uDMA
- data_valid_o  output  1  FIFO not empty
- data_ready_i  input  1  uDMA accepts head word
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current occupancy
- ovf_o  output  1  sticky overflow flag
- ovf_cnt_o  output  OVF_CNT_WIDTH  dropped-word count, saturating

Behaviour:
- Clock, reset and register timing:
  - Only clk_i is used; every register is updated on its rising edge.
  - rst_i=1 for one clock returns all state to its reset value: FIFO empty, ch_idx=0, half_valid=0, ovf=0, count=0.
  - Output reset values: data_o=0, data_valid_o=0, fifo_level_o=0, ovf_o=0, ovf_cnt_o=0.
  - Reset mid-operation discards FIFO contents and any partial word.
- Channel tracking:
  - ch_idx advances on each accepted sample: 0,1,..,cfg_ch_num_i, then wraps to 0.
  - It advances even when the word is dropped, so channel alignment is never lost.
- Packing state machine (cfg_pack_i=1), states EMPTY_HALF and HAVE_LOW:
  - EMPTY_HALF + sample: latch sample into the low half, go to HAVE_LOW.
  - HAVE_LOW + sample: commit word = {sample, latched_low}, go to EMPTY_HALF.
  - For an odd channel count, pairs straddle frames; no realignment is performed.
- Unpacked mode (cfg_pack_i=0): every sample commits word = {{16{sample[15]}}, sample}.
- Commit to FIFO:
  - Push in the cycle after the sample strobe (one registered stage).
  - Accepted if FIFO not full, or if full and a pop occurs in the same cycle (data_valid_o & data_ready_i).
  - Otherwise the word is dropped: ovf_o set and ovf_cnt_o incremented, saturating at all-ones.
  - In packed mode a drop loses both samples.
- FIFO:
  - data_o is the head entry, combinational from the storage array.
  - Pop when data_valid_o & data_ready_i. Simultaneous push and pop leaves the level unchanged.
  - Latency: sample strobe at cycle N into an empty FIFO gives data_valid_o=1 at N+2 (commit register at N+1, FIFO write at N+2).
  - data_o is stable while data_valid_o=1 and data_ready_i=0.
- Disable:
  - cfg_en_i=0 ignores pcm_data_valid_i, resets ch_idx to 0 and discards any HAVE_LOW half (state returns to EMPTY_HALF).
  - The FIFO is not flushed and keeps draining to the uDMA.
- Configuration changes: cfg_ch_num_i and cfg_pack_i may change only while cfg_en_i=0; otherwise behaviour is undefined.
- Overflow clear:
  - ovf_clr_i=1 clears ovf_o and ovf_cnt_o next cycle.
  - If it coincides with a drop, the drop wins: ovf_o=1, ovf_cnt_o=1.

Optional Feature:
- Macro: PDM_PACKER_CH_TAG_EN.
- Defined:
  - In unpacked mode, word = {ch_idx[1:0], {14{sample[15]}}, sample}, so bits [31:30] carry the channel of the sample.
  - In packed mode, the tag is that of the high sample, placed in bits [31:30], overwriting the top two sample bits.
  - Software must therefore use unpacked mode when tags are needed.
- Undefined: no tag logic is instantiated; formatting is exactly as in Behaviour.

Test Plan:
- Unpacked, 1 channel, ready=1: samples 0x1234, 0x8001 -> data_o 0x00001234 then 0xFFFF8001, each valid 2 cycles after its strobe.
- Packed, 2 channels: samples 0xAAAA, 0x5555, 0x0001, 0x0002 -> words 0x5555AAAA, 0x00020001; fifo_level_o peaks at 1 with ready=1.
- Overflow, DEPTH=4, ready=0, unpacked: 6 samples -> fifo_level_o=4, ovf_o=1, ovf_cnt_o=2. Then ready=1 drains samples 1..4 in order. Pulse ovf_clr_i -> ovf_o=0, ovf_cnt_o=0.
- Full FIFO with a push and pop in the same cycle -> no drop, level stays 4, ovf_o stays 0.
- Packed mode, one sample then cfg_en_i=0 -> no word committed. Re-enable, then samples 0x0003, 0x0004 -> word 0x00040003.
- With PDM_PACKER_CH_TAG_EN, 4 channels unpacked: 8 samples of 0x0010 -> bits [31:30] of the words read 0,1,2,3,0,1,2,3. Assert rst_i mid-stream -> FIFO empty, tag restarts at 0.
